dispatcher: RTL

Issue stage between instruction decode and the execution pipes (ALU, MUL, DIV, LSU). Consumes the registered decode bundle, reads source operands from the architectural register file, tracks in-flight destination registers in a scoreboard, and issues one instruction per cycle to exactly one execution pipe. Holds decode via `dispatch_stall` on RAW/WAW hazards or a busy target pipe.

---
 rtl/dispatcher_pkg.sv | 42 ++++
 rtl/dispatcher_if.sv | 21 ++
 rtl/dispatcher_register_file.sv | 27 ++
 rtl/dispatcher.sv | 55 +++++
 4 files changed

// File: rtl/dispatcher_pkg.sv
// dispatcher_pkg: shared types and sizes for the issue stage and its execution-pipe bundles
package dispatcher_pkg;
  localparam int REG_COUNT = 32;
  localparam int XLEN = 32;
  localparam int NUM_PIPES = 4;
  localparam int REG_WIDTH = $clog2(REG_COUNT);
  localparam int EXE_PIPE_ID_ALU = 0;
  localparam int EXE_PIPE_ID_MUL = 1;
  localparam int EXE_PIPE_ID_DIV = 2;
  localparam int EXE_PIPE_ID_LSU = 3;
  // One-hot pipe select so it can be AND-ed with pipe_ready and copied to exe_valid
  typedef enum logic [NUM_PIPES-1:0] {
    EXE_PIPE_INVALID = 4'b0000,
    EXE_PIPE_ALU     = 4'(1 << EXE_PIPE_ID_ALU),
    EXE_PIPE_MUL     = 4'(1 << EXE_PIPE_ID_MUL),
    EXE_PIPE_DIV     = 4'(1 << EXE_PIPE_ID_DIV),
    EXE_PIPE_LSU     = 4'(1 << EXE_PIPE_ID_LSU)
  } exe_pipe_e;
  typedef struct packed {
    exe_pipe_e exe_pipe;
    logic register_write;
    logic [3:0] op;
  } ctrl_t;
  typedef struct packed {
    ctrl_t ctrl;
    logic [REG_WIDTH-1:0] a1;
    logic [REG_WIDTH-1:0] a2;
    logic [REG_WIDTH-1:0] rd;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_inc;
  } id_dispatcher_inf_t;
  typedef struct packed {
    ctrl_t ctrl;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [REG_WIDTH-1:0] rd;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_inc;
  } dispatcher_exe_inf_t;
endpackage

// File: rtl/dispatcher_if.sv
// dispatcher_if: decode-in, writeback-in and execution-out signals of the issue stage
interface dispatcher_if;
  import dispatcher_pkg::*;
  logic flush;
  id_dispatcher_inf_t id_dispatcher_inf;
  logic [NUM_PIPES-1:0] pipe_ready;
  logic wb_valid;
  logic [REG_WIDTH-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic dispatch_stall;
  logic [NUM_PIPES-1:0] exe_valid;
  dispatcher_exe_inf_t dispatcher_exe_inf;
  modport master (
    output flush, id_dispatcher_inf, pipe_ready, wb_valid, wb_rd, wb_data,
    input dispatch_stall, exe_valid, dispatcher_exe_inf
  );
  modport slave (
    input flush, id_dispatcher_inf, pipe_ready, wb_valid, wb_rd, wb_data,
    output dispatch_stall, exe_valid, dispatcher_exe_inf
  );
endinterface

// File: rtl/dispatcher_register_file.sv
// dispatcher_register_file: 2 async read / 1 sync write regfile, x0 hard zero.
// DISPATCH_WB_BYPASS_EN adds write-through of the incoming write to both read ports.
module dispatcher_register_file
  import dispatcher_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic [REG_WIDTH-1:0] ra1,
  input  logic [REG_WIDTH-1:0] ra2,
  input  logic we,
  input  logic [REG_WIDTH-1:0] wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  logic [XLEN-1:0] regs [REG_COUNT];
  always_ff @(posedge clk or negedge rst)
    if (!rst) regs <= '{default: '0};
    else if (we && wa != '0) regs[wa] <= wd;
`ifdef DISPATCH_WB_BYPASS_EN
  assign rd1 = ra1 == '0 ? '0 : (we && wa == ra1) ? wd : regs[ra1];
  assign rd2 = ra2 == '0 ? '0 : (we && wa == ra2) ? wd : regs[ra2];
`else
  assign rd1 = ra1 == '0 ? '0 : regs[ra1];
  assign rd2 = ra2 == '0 ? '0 : regs[ra2];
`endif
endmodule

// File: rtl/dispatcher.sv
// dispatcher: scoreboarded single-issue stage feeding ALU/MUL/DIV/LSU pipes.
// DISPATCH_WB_BYPASS_EN lets a same-cycle writeback clear the hazard and forward its data.
module dispatcher
  import dispatcher_pkg::*;
(
  input logic clk,
  input logic rst,
  dispatcher_if.slave d
);
  id_dispatcher_inf_t in;
  logic [REG_COUNT-1:0] busy, busy_eff, busy_nxt, wb_mask;
  logic valid, hazard, issue;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [NUM_PIPES-1:0] exe_valid_q;
  dispatcher_exe_inf_t issued, out_q;
  assign in = d.id_dispatcher_inf;
  assign valid = in.ctrl.exe_pipe != EXE_PIPE_INVALID;
  assign wb_mask = REG_COUNT'(d.wb_valid && d.wb_rd != '0) << d.wb_rd;
`ifdef DISPATCH_WB_BYPASS_EN
  assign busy_eff = busy & ~wb_mask;
`else
  assign busy_eff = busy;
`endif
  assign hazard = valid && (busy_eff[in.a1] || busy_eff[in.a2] ||
                  (in.ctrl.register_write && busy_eff[in.rd]) ||
                  !(|(in.ctrl.exe_pipe & d.pipe_ready)));
  assign issue = valid && !hazard && !d.flush;
  assign d.dispatch_stall = hazard && !d.flush;
  // Issue set is applied after the writeback clear so a coincident pair leaves the bit set
  always_comb begin
    busy_nxt = busy & ~wb_mask;
    if (issue && in.ctrl.register_write) busy_nxt[in.rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  dispatcher_register_file u_rf (
    .clk(clk), .rst(rst),
    .ra1(in.a1), .ra2(in.a2),
    .we(d.wb_valid), .wa(d.wb_rd), .wd(d.wb_data),
    .rd1(rs1_data), .rd2(rs2_data)
  );
  assign issued = '{ctrl: in.ctrl, rs1_data: rs1_data, rs2_data: rs2_data, rd: in.rd,
                    imm_ext: in.imm_ext, pc: in.pc, pc_inc: in.pc_inc};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      busy <= '0;
      exe_valid_q <= '0;
      out_q <= '0;
    end else begin
      busy <= busy_nxt;
      exe_valid_q <= issue ? NUM_PIPES'(in.ctrl.exe_pipe) : '0;
      out_q <= issue ? issued : '0;
    end
  assign d.exe_valid = exe_valid_q;
  assign d.dispatcher_exe_inf = out_q;
endmodule
